fp_mul_round_pack: RTL and testbench
====================================

Name: fp_mul_round_pack

Overview:
- Post-multiply stage: consumes the raw 48-bit significand product, sign and unbiased exponent sum from the FP multiplier datapath.
- Normalises, rounds to nearest-even, applies overflow/underflow and special-operand rules, and packs an IEEE-754 single-precision result with exception flags.
- Two-stage valid/ready pipeline; sits between the multiplier core and the result writeback/output register.

Parameters:
- EXP_W, 10, width of signed exponent-sum path (must cover -126..383)
- FLUSH_DENORM, 1, 1 = results below the normal range flush to signed zero (only supported value)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream data valid
- in_ready  out  1  stage can accept this cycle
- in_sign  in  1  sign of product (A_sign ^ B_sign)
- in_exp_sum  in  EXP_W  signed, Ea + Eb - 127
- in_mant_prod  in  48  {1,Ma} * {1,Mb}
- in_class_a  in  2  operand A class: 0 zero/denormal, 1 normal, 2 inf, 3 NaN
- in_class_b  in  2  operand B class, same encoding
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_result  out  32  packed IEEE-754 single
- out_flags  out  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Reset (clk edge with reset=1): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_flags=0. Reset mid-operation discards all in-flight items; no partial output.
- Global advance: en = !out_valid | out_ready. in_ready = en. All pipeline registers load only when en=1. Bubbles are not collapsed.
- Transfer occurs on in_valid & in_ready (input) and out_valid & out_ready (output).
- Latency: 2 cycles from accepted input to out_valid with out_ready held high; throughput 1/cycle.
- out_result and out_flags hold stable while out_valid=1 and out_ready=0.
- Stage 1, normalise:
  - If prod[47]=1: M=prod[46:24], G=prod[23], S=|prod[22:0], E=exp_sum+1.
  - Else: M=prod[45:23], G=prod[22], S=|prod[21:0], E=exp_sum.
  - Register M, G, S, E, sign and the special-case code.
- Stage 2, round and pack:
  - inc = G & (S | M[0]); {c,M'} = M + inc (24-bit add).
  - If c=1: M'=0, E=E+1.
  - inexact = G | S.
  - E >= 255: result {sign, 0xFF, 0}; flags overflow=1, inexact=1.
  - E <= 0: result {sign, 0, 0}; flags underflow=1, inexact=1.
  - Else: result {sign, E[7:0], M'}.
- Special cases, decided in stage 1 and overriding the arithmetic path:
  - Either operand NaN: 0x7FC00000, no flags.
  - inf × zero (either order): 0x7FC00000, invalid=1.
  - inf × (inf or normal): {sign, 0xFF, 0}, no flags.
  - zero × (zero or normal): {sign, 0, 0}, no flags.
- Denormal inputs are classed as zero upstream; this block never produces denormals.
- Simultaneous input accept and output handoff in the same cycle is legal and loses no data.

Decomposition:
- Package fp_pkg:
  - fp_class_t enum (ZERO, NORMAL, INF, NAN)
  - constants FP_QNAN=32'h7FC00000, FP_EXP_MAX=255, FP_BIAS=127
  - fp_flags_t packed struct {invalid, overflow, underflow, inexact}
- One natural sub-module, fp_round_rne: combinational M, G, S, E in → M', E', inexact out. Reusable by the adder's post-stage.

Test Plan:
- prod=0x900000000000, exp_sum=127, sign=0, both classes normal -> after 2 cycles 0x40100000 (2.25), flags 0.
- Tie rounding, exp_sum=127: prod=0x400000400000 -> 0x3F800000, inexact; prod=0x400000C00000 -> 0x3F800002, inexact.
- prod=0x7FFFFFC00000, exp_sum=127 -> rounding carry gives 0x40000000, inexact.
- exp_sum=254, prod=0x800000000000 -> 0x7F800000, overflow+inexact. exp_sum=0, prod=0x400000000000, sign=1 -> 0x80000000, underflow+inexact.
- class_a=INF, class_b=ZERO -> 0x7FC00000, invalid. class_a=NAN -> 0x7FC00000, flags 0. class_a=INF, class_b=NORMAL, sign=1 -> 0xFF800000.
- Backpressure: stream 4 items, hold out_ready=0 for 3 cycles after first out_valid -> in_ready=0 during stall, output stable, all 4 results delivered in order. Assert reset with 2 items in flight -> out_valid=0 next cycle, no stale result afterwards.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision multiplier post-stage.
//   fp_class_t   : operand class as delivered by the unpacking stage
//   fp_flags_t   : exception flags {invalid, overflow, underflow, inexact}
//   fp_special_t : special-operand outcome decided before rounding
package fp_pkg;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        NORMAL = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } fp_class_t;

    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
    localparam int          FP_EXP_MAX = 255;
    localparam int          FP_BIAS    = 127;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    typedef enum logic [2:0] {
        SpNone,
        SpQnan,
        SpInvalid,
        SpInf,
        SpZero
    } fp_special_t;

    // Priority matters: NaN beats inf*zero, which beats the plain inf and zero cases.
    function automatic fp_special_t fp_special(input fp_class_t a, input fp_class_t b);
        if (a == NAN || b == NAN) return SpQnan;
        if ((a == INF && b == ZERO) || (a == ZERO && b == INF)) return SpInvalid;
        if (a == INF || b == INF) return SpInf;
        if (a == ZERO || b == ZERO) return SpZero;
        return SpNone;
    endfunction

endpackage

// File: rtl/fp_mul_round_pack_if.sv
// Valid/ready bundle between the multiplier core, the post-stage and writeback.
//   in_*  : raw product, sign, exponent sum and operand classes (upstream -> stage)
//   out_* : packed IEEE-754 single result and flags (stage -> downstream)
// master = driver of the inputs / consumer of results; slave = the post-stage.
interface fp_mul_round_pack_if #(
    parameter int EXP_W = 10
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sign;
    logic [EXP_W-1:0] in_exp_sum;
    logic [47:0]      in_mant_prod;
    logic [1:0]       in_class_a;
    logic [1:0]       in_class_b;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [3:0]       out_flags;

    modport master (
        output in_valid, in_sign, in_exp_sum, in_mant_prod, in_class_a, in_class_b, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_exp_sum, in_mant_prod, in_class_a, in_class_b, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised 23-bit fraction.
//   mant, guard, sticky, exp_in : normalised fraction, guard/sticky bits, signed exponent
//   mant_out, exp_out           : rounded fraction and exponent (bumped on carry-out)
//   inexact                     : any discarded bit was non-zero
module fp_round_rne #(
    parameter int EXP_W = 10
) (
    input  logic [22:0]             mant,
    input  logic                    guard,
    input  logic                    sticky,
    input  logic signed [EXP_W-1:0] exp_in,
    output logic [22:0]             mant_out,
    output logic signed [EXP_W-1:0] exp_out,
    output logic                    inexact
);
    logic        inc;
    logic [23:0] sum;

    assign inc      = guard & (sticky | mant[0]);
    assign sum      = {1'b0, mant} + 24'(inc);
    // On carry-out the fraction wraps to zero, which is exactly the renormalised value.
    assign mant_out = sum[22:0];
    assign exp_out  = exp_in + EXP_W'(sum[23]);
    assign inexact  = guard | sticky;
endmodule

// File: rtl/fp_mul_round_pack.sv
// Multiplier post-stage: normalise (stage 1), round/pack/flag (stage 2).
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of fp_mul_round_pack_if (in_* product, out_* result/flags)
// Both stages advance together when the output register is free or being drained.
module fp_mul_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W        = 10,
    parameter bit FLUSH_DENORM = 1'b1
) (
    input  logic clk,
    input  logic reset,
    fp_mul_round_pack_if.slave bus
);
    localparam logic signed [EXP_W-1:0] ExpMax = EXP_W'(FP_EXP_MAX);
    localparam logic signed [EXP_W-1:0] ExpOne = EXP_W'(1);

    logic en;

    // Stage 1 next-state and registers.
    logic [22:0]             m_d, m_q;
    logic                    g_d, g_q;
    logic                    s_d, s_q;
    logic signed [EXP_W-1:0] e_d, e_q;
    logic                    sign_q;
    fp_special_t             sp_q;
    logic                    s1_valid_q;

    // Stage 2 rounding results and output registers.
    logic [22:0]             m_r;
    logic signed [EXP_W-1:0] e_r;
    logic                    inexact_r;
    logic [31:0]             result_d, out_result_q;
    fp_flags_t               flags_d, out_flags_q;
    logic                    out_valid_q;

    assign en           = !out_valid_q | bus.out_ready;
    assign bus.in_ready = en;

    always_comb begin
        if (bus.in_mant_prod[47]) begin
            m_d = bus.in_mant_prod[46:24];
            g_d = bus.in_mant_prod[23];
            s_d = |bus.in_mant_prod[22:0];
            e_d = $signed(bus.in_exp_sum) + ExpOne;
        end else begin
            m_d = bus.in_mant_prod[45:23];
            g_d = bus.in_mant_prod[22];
            s_d = |bus.in_mant_prod[21:0];
            e_d = $signed(bus.in_exp_sum);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
        end else if (en) begin
            s1_valid_q <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            m_q    <= m_d;
            g_q    <= g_d;
            s_q    <= s_d;
            e_q    <= e_d;
            sign_q <= bus.in_sign;
            sp_q   <= fp_special(fp_class_t'(bus.in_class_a), fp_class_t'(bus.in_class_b));
        end
    end

    fp_round_rne #(
        .EXP_W(EXP_W)
    ) u_round (
        .mant    (m_q),
        .guard   (g_q),
        .sticky  (s_q),
        .exp_in  (e_q),
        .mant_out(m_r),
        .exp_out (e_r),
        .inexact (inexact_r)
    );

    always_comb begin
        result_d        = {sign_q, e_r[7:0], m_r};
        flags_d         = '0;
        flags_d.inexact = inexact_r;
        unique case (sp_q)
            SpQnan: begin
                result_d = FP_QNAN;
                flags_d  = '0;
            end
            SpInvalid: begin
                result_d        = FP_QNAN;
                flags_d         = '0;
                flags_d.invalid = 1'b1;
            end
            SpInf: begin
                result_d = {sign_q, 8'hFF, 23'h0};
                flags_d  = '0;
            end
            SpZero: begin
                result_d = {sign_q, 31'h0};
                flags_d  = '0;
            end
            default: begin
                if (e_r >= ExpMax) begin
                    result_d          = {sign_q, 8'hFF, 23'h0};
                    flags_d.overflow  = 1'b1;
                    flags_d.inexact   = 1'b1;
                end else if (FLUSH_DENORM && e_r < ExpOne) begin
                    result_d          = {sign_q, 31'h0};
                    flags_d.underflow = 1'b1;
                    flags_d.inexact   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
        end else if (en) begin
            out_valid_q  <= s1_valid_q;
            out_result_q <= result_d;
            out_flags_q  <= flags_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_flags  = out_flags_q;
endmodule

// File: tb/tb_fp_mul_round_pack.sv
module tb_fp_mul_round_pack;
    logic clk;
    logic reset;

    fp_mul_round_pack_if #(.EXP_W(10)) bus ();

    fp_mul_round_pack #(
        .EXP_W       (10),
        .FLUSH_DENORM(1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int delivered;

    // Two-slot occupancy model of the pipe: slot 1 is what the output should show.
    logic        m_valid [2];
    logic [35:0] m_data  [2];

    typedef struct {
        logic        s;
        int          e;
        logic [47:0] p;
        logic [1:0]  ca;
        logic [1:0]  cb;
        logic [35:0] expv;
    } dir_t;

    dir_t        dirs [10];
    logic [47:0] bp_p [4];

    // Reference: integer rounding of the product, then range and special-operand rules.
    function automatic logic [35:0] ref_model(input logic s, input int e, input logic [47:0] p,
                                              input logic [1:0] ca, input logic [1:0] cb);
        longint unsigned pv, q, rem, half;
        int sh, ee;
        logic inexact;
        if (ca == 2'd3 || cb == 2'd3) return {4'b0000, 32'h7FC00000};
        if ((ca == 2'd2 && cb == 2'd0) || (ca == 2'd0 && cb == 2'd2))
            return {4'b1000, 32'h7FC00000};
        if (ca == 2'd2 || cb == 2'd2) return {4'b0000, s, 8'hFF, 23'h0};
        if (ca == 2'd0 || cb == 2'd0) return {4'b0000, s, 31'h0};
        pv   = 64'(p);
        sh   = p[47] ? 24 : 23;
        ee   = p[47] ? e + 1 : e;
        q    = pv >> sh;
        rem  = pv & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        if (q == (64'd1 << 24)) begin
            q  = q >> 1;
            ee = ee + 1;
        end
        inexact = (rem != 0);
        if (ee >= 255) return {4'b0101, s, 8'hFF, 23'h0};
        if (ee <= 0) return {4'b0011, s, 31'h0};
        return {3'b000, inexact, s, 8'(ee), q[22:0]};
    endfunction

    task automatic drive(input logic v, input logic s, input int e, input logic [47:0] p,
                         input logic [1:0] ca, input logic [1:0] cb, input logic ordy,
                         input logic [35:0] expv);
        logic en_m;
        bus.in_valid     = v;
        bus.in_sign      = s;
        bus.in_exp_sum   = 10'(e);
        bus.in_mant_prod = p;
        bus.in_class_a   = ca;
        bus.in_class_b   = cb;
        bus.out_ready    = ordy;
        #1;
        en_m = !m_valid[1] || ordy;
        checks++;
        assert (bus.in_ready === en_m) else begin
            errors++;
            $error("FAIL in_ready got %b want %b", bus.in_ready, en_m);
        end
        checks++;
        assert (bus.out_valid === m_valid[1]) else begin
            errors++;
            $error("FAIL out_valid got %b want %b", bus.out_valid, m_valid[1]);
        end
        if (m_valid[1]) begin
            checks++;
            assert (bus.out_result === m_data[1][31:0]) else begin
                errors++;
                $error("FAIL out_result got %h want %h", bus.out_result, m_data[1][31:0]);
            end
            checks++;
            assert (bus.out_flags === m_data[1][35:32]) else begin
                errors++;
                $error("FAIL out_flags got %b want %b", bus.out_flags, m_data[1][35:32]);
            end
        end
        if (bus.out_valid && ordy) delivered++;
        @(posedge clk);
        if (en_m) begin
            m_valid[1] = m_valid[0];
            m_data[1]  = m_data[0];
            m_valid[0] = v;
            m_data[0]  = expv;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 48'h0, 2'd1, 2'd1, 1'b1, 36'h0);
    endtask

    function automatic logic [1:0] rand_class();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 2'd0;
        if (r == 1) return 2'd2;
        if (r == 2) return 2'd3;
        return 2'd1;
    endfunction

    function automatic logic [47:0] rand_prod();
        logic [23:0] ma, mb;
        ma = {1'b1, 23'($urandom)};
        mb = {1'b1, 23'($urandom)};
        return 48'(ma) * 48'(mb);
    endfunction

    initial begin
        dirs[0] = '{1'b0, 127, 48'h900000000000, 2'd1, 2'd1, {4'b0000, 32'h40100000}};
        dirs[1] = '{1'b0, 127, 48'h400000400000, 2'd1, 2'd1, {4'b0001, 32'h3F800000}};
        dirs[2] = '{1'b0, 127, 48'h400000C00000, 2'd1, 2'd1, {4'b0001, 32'h3F800002}};
        dirs[3] = '{1'b0, 127, 48'h7FFFFFC00000, 2'd1, 2'd1, {4'b0001, 32'h40000000}};
        dirs[4] = '{1'b0, 254, 48'h800000000000, 2'd1, 2'd1, {4'b0101, 32'h7F800000}};
        dirs[5] = '{1'b1, 0,   48'h400000000000, 2'd1, 2'd1, {4'b0011, 32'h80000000}};
        dirs[6] = '{1'b0, 127, 48'h400000000000, 2'd2, 2'd0, {4'b1000, 32'h7FC00000}};
        dirs[7] = '{1'b1, 127, 48'h400000000000, 2'd3, 2'd1, {4'b0000, 32'h7FC00000}};
        dirs[8] = '{1'b1, 127, 48'h400000000000, 2'd2, 2'd1, {4'b0000, 32'hFF800000}};
        dirs[9] = '{1'b1, 127, 48'h400000000000, 2'd0, 2'd1, {4'b0000, 32'h80000000}};

        m_valid          = '{1'b0, 1'b0};
        m_data           = '{36'h0, 36'h0};
        delivered        = 0;
        reset            = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_sign      = 1'b0;
        bus.in_exp_sum   = '0;
        bus.in_mant_prod = '0;
        bus.in_class_a   = 2'd1;
        bus.in_class_b   = 2'd1;
        bus.out_ready    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        assert ({bus.out_valid, bus.out_result, bus.out_flags} === 37'h0) else begin
            errors++;
            $error("FAIL reset_state got %b/%h/%b want 0/0/0",
                   bus.out_valid, bus.out_result, bus.out_flags);
        end
        reset = 1'b0;

        // Directed: one item at a time, result must appear exactly two cycles later.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, dirs[i].s, dirs[i].e, dirs[i].p, dirs[i].ca, dirs[i].cb, 1'b1,
                  dirs[i].expv);
            idle(2);
        end

        // Back-to-back directed stream at full rate.
        for (int i = 0; i < 10; i++)
            drive(1'b1, dirs[i].s, dirs[i].e, dirs[i].p, dirs[i].ca, dirs[i].cb, 1'b1,
                  dirs[i].expv);
        idle(3);

        // Backpressure: four items, output stalled for three cycles after the first result.
        for (int i = 0; i < 4; i++) bp_p[i] = rand_prod();
        begin
            int idx;
            logic ordy, acc;
            idx       = 0;
            delivered = 0;
            for (int c = 0; c < 20 && (idx < 4 || m_valid[0] || m_valid[1]); c++) begin
                ordy = !(c >= 2 && c <= 4);
                acc  = (idx < 4) && (!m_valid[1] || ordy);
                if (idx < 4)
                    drive(1'b1, 1'b0, 100 + idx, bp_p[idx], 2'd1, 2'd1, ordy,
                          ref_model(1'b0, 100 + idx, bp_p[idx], 2'd1, 2'd1));
                else
                    drive(1'b0, 1'b0, 0, 48'h0, 2'd1, 2'd1, ordy, 36'h0);
                if (acc) idx++;
            end
            checks++;
            assert (delivered == 4) else begin
                errors++;
                $error("FAIL bp_delivered got %0d want 4", delivered);
            end
        end

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            logic s, v, ordy;
            logic [47:0] p;
            logic [1:0] ca, cb;
            int e;
            s    = 1'($urandom);
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            p    = rand_prod();
            e    = int'($urandom_range(0, 509)) - 126;
            ca   = rand_class();
            cb   = rand_class();
            drive(v, s, e, p, ca, cb, ordy, ref_model(s, e, p, ca, cb));
        end
        idle(3);

        // Reset with two items in flight: nothing may emerge afterwards.
        drive(1'b1, 1'b0, 127, 48'h900000000000, 2'd1, 2'd1, 1'b1, {4'b0000, 32'h40100000});
        drive(1'b1, 1'b1, 127, 48'h900000000000, 2'd1, 2'd1, 1'b1, {4'b0000, 32'hC0100000});
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        m_valid = '{1'b0, 1'b0};
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
